// File: rtl/xctcmsg_piton_pkg.sv
// Shared types for the OpenPiton NoC message receiver: header/payload layouts,
// width constants and the receiver FSM state encoding.
package xctcmsg_piton_pkg;

  localparam int NOC_HEADER_WIDTH       = 64;
  localparam int NOC_PAYLOAD_WIDTH      = 128;
  localparam int NOC_MSG_PAYLOAD_LENGTH = 2;
  localparam int NOC_FLIT_WIDTH         = 64;
  localparam int NOC_MSG_DST_X_WIDTH    = 8;
  localparam int NOC_MSG_DST_Y_WIDTH    = 8;
  localparam int NOC_MSG_LENGTH_WIDTH   = 8;
  localparam int DROP_COUNT_WIDTH       = 8;

  typedef logic [31:0] message_addr_t;
  typedef logic [31:0] message_tag_t;
  typedef logic [63:0] message_data_t;

  // Header field order follows the OpenPiton flit layout, MSB first.
  typedef struct packed {
    logic [13:0]                         chipid;
    logic [NOC_MSG_DST_X_WIDTH-1:0]      dst_x;
    logic [NOC_MSG_DST_Y_WIDTH-1:0]      dst_y;
    logic [3:0]                          fbits;
    logic [NOC_MSG_LENGTH_WIDTH-1:0]     length;
    logic [7:0]                          msg_type;
    logic [7:0]                          mshr;
    logic [5:0]                          reserved;
  } noc_header_parts_t;

  typedef union packed {
    logic [NOC_HEADER_WIDTH-1:0] raw;
    noc_header_parts_t           parts;
  } openpiton_noc_header_t;

  typedef struct packed {
    message_data_t data;
    message_tag_t  tag;
    message_addr_t source;
  } noc_payload_parts_t;

  typedef union packed {
    logic [NOC_PAYLOAD_WIDTH-1:0] raw;
    noc_payload_parts_t           parts;
  } openpiton_noc_payload_t;

  typedef enum logic [2:0] {
    ST_HEADER  = 3'd0,
    ST_PAY0    = 3'd1,
    ST_PAY1    = 3'd2,
    ST_DELIVER = 3'd3,
    ST_DRAIN   = 3'd4
  } rx_state_e;

  // A header is ours only if it carries exactly one message payload and targets this tile.
  function automatic logic header_match(
    input openpiton_noc_header_t          hdr,
    input logic [NOC_MSG_DST_X_WIDTH-1:0] my_x,
    input logic [NOC_MSG_DST_Y_WIDTH-1:0] my_y
  );
    return (hdr.parts.length == NOC_MSG_LENGTH_WIDTH'(NOC_MSG_PAYLOAD_LENGTH)) &&
           (hdr.parts.dst_x == my_x) && (hdr.parts.dst_y == my_y);
  endfunction

endpackage

// File: rtl/xctcmsg_piton_receiver.sv
// Receives OpenPiton NoC messages addressed to this tile, delivers the 2-flit
// payload over a valid/ready port and drains/counts anything else.
module xctcmsg_piton_receiver
  import xctcmsg_piton_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NOC_MSG_DST_X_WIDTH-1:0] my_x_i,
  input  logic [NOC_MSG_DST_Y_WIDTH-1:0] my_y_i,
  input  logic                           noc_valid_i,
  input  logic [NOC_FLIT_WIDTH-1:0]      noc_data_i,
  output logic                           noc_ready_o,
  output logic                           msg_valid_o,
  input  logic                           msg_ready_i,
  output message_addr_t                  msg_source_o,
  output message_tag_t                   msg_tag_o,
  output message_data_t                  msg_data_o,
  output logic                           drop_o,
  output logic [DROP_COUNT_WIDTH-1:0]    drop_count_o
);

  rx_state_e                       state;
  logic [NOC_MSG_LENGTH_WIDTH-1:0] drain_cnt;
  openpiton_noc_payload_t          payload;
  openpiton_noc_header_t           hdr;
  logic                            flit_fire;

  assign hdr       = noc_data_i;
  assign flit_fire = noc_valid_i && noc_ready_o;

  // Handshake flags come straight from the state register, so neither depends
  // combinationally on the opposite side's valid/ready.
  assign noc_ready_o = (state != ST_DELIVER);
  assign msg_valid_o = (state == ST_DELIVER);

  assign msg_source_o = payload.parts.source;
  assign msg_tag_o    = payload.parts.tag;
  assign msg_data_o   = payload.parts.data;

  // NOTE: every register in this block uses <= so all updates see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_HEADER;
      drain_cnt    <= '0;
      // NOTE: the payload register is reset so the message outputs read zero after reset.
      payload      <= '0;
      drop_o       <= 1'b0;
      drop_count_o <= '0;
    end else begin
      drop_o <= 1'b0;
      unique case (state)
        ST_HEADER: begin
          if (flit_fire) begin
            if (header_match(hdr, my_x_i, my_y_i)) begin
              state <= ST_PAY0;
            end else begin
              drop_o <= 1'b1;
              if (drop_count_o != '1) drop_count_o <= drop_count_o + 8'd1;
              if (hdr.parts.length != '0) begin
                drain_cnt <= hdr.parts.length;
                state     <= ST_DRAIN;
              end
            end
          end
        end
        ST_PAY0: begin
          if (flit_fire) begin
            payload.raw[NOC_FLIT_WIDTH-1:0] <= noc_data_i;
            state                           <= ST_PAY1;
          end
        end
        ST_PAY1: begin
          if (flit_fire) begin
            payload.raw[NOC_PAYLOAD_WIDTH-1:NOC_FLIT_WIDTH] <= noc_data_i;
            state                                           <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (msg_ready_i) state <= ST_HEADER;
        end
        ST_DRAIN: begin
          if (flit_fire) begin
            drain_cnt <= drain_cnt - 8'd1;
            if (drain_cnt == 8'd1) state <= ST_HEADER;
          end
        end
        default: state <= ST_HEADER;
      endcase
    end
  end

endmodule

// File: doc/xctcmsg_piton_receiver.md
XCTCMSG_PITON_RECEIVER -- requirements
Module: xctcmsg_piton_receiver

Interface
REQ-001 SHALL have no parameters; all widths come from xctcmsg_piton_pkg (NOC_HEADER_WIDTH=64, NOC_PAYLOAD_WIDTH=128, NOC_MSG_PAYLOAD_LENGTH=2).
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assertion, active-low.
REQ-004 my_x_i / my_y_i  input  NOC_MSG_DST_X_WIDTH / NOC_MSG_DST_Y_WIDTH  own tile coordinates, held quasi-static.
REQ-005 noc_valid_i  input  1  incoming NoC flit valid.
REQ-006 noc_data_i  input  64  incoming flit.
REQ-007 noc_ready_o  output  1  flit accepted when noc_valid_i && noc_ready_o.
REQ-008 msg_valid_o  output  1  decoded message available.
REQ-009 msg_ready_i  input  1  consumer accepts when msg_valid_o && msg_ready_i.
REQ-010 msg_source_o / msg_tag_o / msg_data_o  output  message_addr_t / message_tag_t / message_data_t  decoded payload fields.
REQ-011 drop_o  output  1  one-cycle pulse per discarded message.
REQ-012 drop_count_o  output  8  saturating count of discarded messages.

Function
REQ-013 SHALL implement FSM states HEADER, PAY0, PAY1, DELIVER, DRAIN; reset state HEADER.
REQ-014 noc_ready_o SHALL be 1 in HEADER, PAY0, PAY1, DRAIN and 0 in DELIVER, decoded from state only (no combinational path from msg_ready_i or noc_valid_i).
REQ-015 HEADER: on accepted flit, decode it as openpiton_noc_header_t.parts; accept the message when length==2, dst_x==my_x_i, and dst_y==my_y_i.
REQ-016 HEADER, accepted message: go to PAY0.
REQ-017 HEADER, rejected message with length==0: pulse drop_o next cycle and stay in HEADER.
REQ-018 HEADER, rejected message with length>0: load the 8-bit drain counter with length, pulse drop_o, go to DRAIN.
REQ-019 DRAIN: each accepted flit decrements the counter; leave to HEADER on the flit that brings it to 0.
REQ-020 PAY0: accepted flit becomes payload raw[63:0]; go to PAY1.
REQ-021 PAY1: accepted flit becomes payload raw[127:64]; go to DELIVER.
REQ-022 Outputs SHALL be the payload register decoded as openpiton_noc_payload_t.parts (data in upper bits, then tag, then source in LSBs).
REQ-023 msg_valid_o SHALL be 1 exactly in DELIVER, i.e. first asserted the cycle after the PAY1 flit handshake (latency 1).
REQ-024 DELIVER: fields SHALL stay stable until the handshake; on msg_ready_i go to HEADER. Maximum throughput is one message per 4 cycles.
REQ-025 Flits presented without noc_valid_i SHALL NOT change state; valid bubbles between flits are allowed in every state.
REQ-026 drop_count_o SHALL increment with each drop_o pulse and saturate at 255.
REQ-027 chipid, fbits, and reserved header fields SHALL be ignored.

Reset
REQ-028 On rst_ni low, immediately: state=HEADER, msg_valid_o=0, noc_ready_o=1 after release, drop_o=0, drop_count_o=0, drain counter=0, payload register=0.
REQ-029 Reset mid-message (PAY0/PAY1/DRAIN/DELIVER) SHALL discard the partial or pending message without a drop_o pulse; the next flit after release is treated as a header.

Structure
REQ-030 The state enum SHALL live in xctcmsg_piton_pkg, alongside a flit-width constant NOC_FLIT_WIDTH=64; all header/payload structs SHALL be reused from the package.
REQ-031 The block SHALL be a single module with no sub-modules; the drain counter and drop counter are inline.

Verification
REQ-032 Good message: header len=2, dst=(my_x,my_y); flits 0x0000_0011_0000_0022 and 0xDEAD_BEEF_CAFE_F00D back-to-back -> msg_valid_o 1 cycle after the last flit, data=0xDEAD_BEEF_CAFE_F00D, tag/source per the low flit; noc_ready_o=0 until msg_ready_i.
REQ-033 Backpressure: hold msg_ready_i=0 for 10 cycles while noc_valid_i=1 -> no flit accepted, outputs stable; accept on cycle 11, then the next header is taken the following cycle.
REQ-034 Wrong destination: len=2, dst_x=my_x+1 -> drop_o pulses once, 2 flits drained, msg_valid_o never asserts, drop_count_o=1.
REQ-035 Length errors: len=0 -> drop with no drain; len=5 -> drop and 5 flits drained; the next good message is delivered correctly.
REQ-036 Saturation/reset: 260 dropped messages -> drop_count_o=255; assert rst_ni mid-PAY1 -> msg_valid_o=0, count=0, and a following good message is delivered.
